// File: rtl/fpadd_vec_pkg.sv
// -----------------------------------------------------------------------------
// fpadd_vec_pkg
// Shared definitions for the vector element sequencer that feeds the
// pipelined single-precision adder:
//   FP_W / FP_SIGN_BIT : IEEE-754 single element width and sign bit position
//   state_e            : sequencer states
//   clog2()            : index-width helper used to size the element tags
//   sign_adjust()      : flips the sign of operand B for a subtract
// -----------------------------------------------------------------------------
package fpadd_vec_pkg;

  localparam int FP_W        = 32;
  localparam int FP_SIGN_BIT = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Smallest r with 2**r >= n; sizes the element index carried in each tag.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // a - b is issued to the adder as a + (-b): only the sign bit changes.
  function automatic logic [FP_W-1:0] sign_adjust(input logic [FP_W-1:0] b,
                                                  input logic            sub);
    logic [FP_W-1:0] r;
    r              = b;
    r[FP_SIGN_BIT] = b[FP_SIGN_BIT] ^ sub;
    return r;
  endfunction

endpackage

// File: rtl/fpadd_tag_pipe.sv
// -----------------------------------------------------------------------------
// fpadd_tag_pipe
// DEPTH-deep shift register of element tags. It travels alongside the adder
// pipeline, so the tag at the tail names the element whose sum is on fa_out.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous, active-high reset (clears every stage)
//   tag_i  : tag pushed this cycle (valid bit cleared when nothing is issued)
//   tail_o : oldest tag, DEPTH cycles after it was pushed
// -----------------------------------------------------------------------------
module fpadd_tag_pipe #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] tag_i,
  output logic [TAG_W-1:0] tail_o
);

  logic [TAG_W-1:0] stage_q [DEPTH];

  // NOTE: every stage is reset, not just the data path -- a stale valid bit
  // left over from an aborted command would otherwise write into result.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value and the shift is order-independent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign tail_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fpadd_vec_seq.sv
// -----------------------------------------------------------------------------
// fpadd_vec_seq
// Vector element sequencer in front of the pipelined fp adder. One start
// captures LANES operand pairs; elements are issued one per cycle, tracked by
// a LAT-deep tag pipeline, and the sums are gathered into a packed result.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   start            : command strobe, honoured only in IDLE
//   sub              : 1 = a-b, 0 = a+b
//   op_a, op_b       : packed operands, element i at [i*W +: W]
//   busy             : command in progress (cycle after start through DONE)
//   done             : one-cycle completion pulse; result valid, then held
//   result           : packed results, element i at [i*W +: W]
//   fa_a, fa_b       : adder operands (fa_b already sign adjusted)
//   fa_en            : adder enable, high while issuing and draining
//   fa_out           : adder result, LAT cycles after its operands
// Build option FPADD_SEQ_PERF_EN adds perf_cmds (accepted commands,
// saturating) and perf_busy (busy cycles, wrapping).
// -----------------------------------------------------------------------------
module fpadd_vec_seq
  import fpadd_vec_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LAT   = 4,
  parameter int W     = FP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sub,
  input  logic [LANES*W-1:0] op_a,
  input  logic [LANES*W-1:0] op_b,
  output logic               busy,
  output logic               done,
  output logic [LANES*W-1:0] result,
  output logic [W-1:0]       fa_a,
  output logic [W-1:0]       fa_b,
  output logic               fa_en,
  input  logic [W-1:0]       fa_out
`ifdef FPADD_SEQ_PERF_EN
  ,
  output logic [15:0]        perf_cmds,
  output logic [31:0]        perf_busy
`endif
);

  localparam int IDX_W = clog2(LANES);
  localparam int TAG_W = 1 + IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LANES*W-1:0] a_q, b_q, result_q;
  logic               sub_q;
  logic [W-1:0]       fa_a_hold_q, fa_b_hold_q;
  logic [W-1:0]       cur_a, cur_b;
  tag_t               push_tag, tail_tag;
  logic               accept;

  assign accept = (state_q == IDLE) && start;
  assign cur_a  = a_q[idx_q*W +: W];
  assign cur_b  = sign_adjust(b_q[idx_q*W +: W], sub_q);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    push_tag = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          idx_d   = '0;
        end
      end
      ISSUE: begin
        push_tag = '{valid: 1'b1, idx: idx_q};
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: begin
        // Elements leave in issue order, so the last lane at the tail means
        // its sum is being written this cycle.
        if (tail_tag.valid && (tail_tag.idx == LAST_IDX)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      fa_a_hold_q <= '0;
      fa_b_hold_q <= '0;
      result_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        a_q   <= op_a;
        b_q   <= op_b;
        sub_q <= sub;
      end
      // Remember the last issued pair so the adder inputs stay put in DRAIN.
      if (state_q == ISSUE) begin
        fa_a_hold_q <= cur_a;
        fa_b_hold_q <= cur_b;
      end
      if (tail_tag.valid) result_q[tail_tag.idx*W +: W] <= fa_out;
    end
  end

  fpadd_tag_pipe #(
    .DEPTH (LAT),
    .TAG_W (TAG_W)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_i  (push_tag),
    .tail_o (tail_tag)
  );

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign fa_en  = (state_q == ISSUE) || (state_q == DRAIN);
  assign fa_a   = (state_q == ISSUE) ? cur_a : fa_a_hold_q;
  assign fa_b   = (state_q == ISSUE) ? cur_b : fa_b_hold_q;
  assign result = result_q;

`ifdef FPADD_SEQ_PERF_EN
  logic [15:0] perf_cmds_q;
  logic [31:0] perf_busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cmds_q <= '0;
      perf_busy_q <= '0;
    end else begin
      if (accept && (perf_cmds_q != 16'hFFFF)) perf_cmds_q <= perf_cmds_q + 16'd1;
      if (busy) perf_busy_q <= perf_busy_q + 32'd1;
    end
  end

  assign perf_cmds = perf_cmds_q;
  assign perf_busy = perf_busy_q;
`endif

endmodule

// File: tb/tb_fpadd_vec_seq.sv
// -----------------------------------------------------------------------------
// tb_fpadd_vec_seq
// Self-checking bench for fpadd_vec_seq (LANES=4, LAT=4). A behavioural adder
// with LAT cycles of latency sits on fa_a/fa_b -> fa_out; it can act as a real
// float adder, a 32-bit integer adder or a pass-through of fa_a. Expected
// vectors, sign handling and cycle timing are computed from the element-wise
// rules, independent of the sequencer's internals. Define FPADD_SEQ_PERF_EN
// to also check the performance counters.
// -----------------------------------------------------------------------------
module tb_fpadd_vec_seq;

  localparam int LANES = 4;
  localparam int LAT   = 4;
  localparam int W     = 32;
  localparam int CMD_CYCLES = LANES + LAT + 1;

  logic               clk;
  logic               rst;
  logic               start;
  logic               sub;
  logic [LANES*W-1:0] op_a, op_b;
  logic               busy, done, fa_en;
  logic [LANES*W-1:0] result;
  logic [W-1:0]       fa_a, fa_b, fa_out;
`ifdef FPADD_SEQ_PERF_EN
  logic [15:0]        perf_cmds;
  logic [31:0]        perf_busy;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int mode     = 0;   // 0: float add, 1: integer add, 2: pass fa_a through

  fpadd_vec_seq #(.LANES(LANES), .LAT(LAT)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .fa_a   (fa_a),
    .fa_b   (fa_b),
    .fa_en  (fa_en),
    .fa_out (fa_out)
`ifdef FPADD_SEQ_PERF_EN
    ,
    .perf_cmds (perf_cmds),
    .perf_busy (perf_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Normal single <-> double conversions, enough for the directed values.
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) return 0.0;
    d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] amodel(input int m, input logic [31:0] x,
                                         input logic [31:0] y);
    case (m)
      0:       return r2sp(sp2r(x) + sp2r(y));
      1:       return x + y;
      default: return x;
    endcase
  endfunction

  // Behavioural adder: operands seen in one cycle appear LAT cycles later.
  logic [31:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= amodel(mode, fa_a, fa_b);
    for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign fa_out = apipe[LAT-1];

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one command and checks its timing, adder stream and results.
  // Cycle k is the k-th clock period after the start edge. With hold set,
  // start stays high throughout and is still high when the task returns.
  task automatic run_cmd(input logic [127:0] a, input logic [127:0] b,
                         input logic s, input bit hold, input string tag);
    logic [127:0] exp_res, exp_fb, got_fa, got_fb;
    logic [31:0]  bb;
    int busy_n, en_n, done_n, done_at;
    for (int i = 0; i < LANES; i++) begin
      bb = b[i*W +: W];
      if (s) bb[31] = ~bb[31];
      exp_fb[i*W +: W]  = bb;
      exp_res[i*W +: W] = amodel(mode, a[i*W +: W], bb);
    end
    got_fa = '0;
    got_fb = '0;
    busy_n = 0; en_n = 0; done_n = 0; done_at = -1;
    op_a = a; op_b = b; sub = s; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        if (!hold) start = 1'b0;
        // Operands are free to change once the command is accepted.
        op_a = {$urandom, $urandom, $urandom, $urandom};
        op_b = {$urandom, $urandom, $urandom, $urandom};
        sub  = ~s;
      end
      if (busy) busy_n++;
      if (fa_en) en_n++;
      if (k <= LANES) begin
        got_fa[(k-1)*W +: W] = fa_a;
        got_fb[(k-1)*W +: W] = fa_b;
      end
      if (done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = k;
          check($sformatf("%s result_at_done", tag), result, exp_res);
        end
      end
      if (done_at > 0 && k == done_at + 1) begin
        check($sformatf("%s busy_after_done", tag), {127'd0, busy}, 128'd0);
        check($sformatf("%s result_held", tag), result, exp_res);
        break;
      end
    end
    check($sformatf("%s done_cycle", tag), 128'(done_at), 128'(CMD_CYCLES));
    check($sformatf("%s done_pulses", tag), 128'(done_n), 128'd1);
    check($sformatf("%s busy_cycles", tag), 128'(busy_n), 128'(CMD_CYCLES));
    check($sformatf("%s fa_en_cycles", tag), 128'(en_n), 128'(LANES + LAT));
    check($sformatf("%s fa_a_seq", tag), got_fa, a);
    check($sformatf("%s fa_b_seq", tag), got_fb, exp_fb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] a, b;

    // Reset state.
    rst = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {127'd0, busy}, 128'd0);
    check("reset done", {127'd0, done}, 128'd0);
    check("reset fa_en", {127'd0, fa_en}, 128'd0);
    check("reset fa_a_fa_b", {64'd0, fa_a, fa_b}, 128'd0);
    check("reset result", result, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Float adds and the subtract path.
    mode = 0;
    run_cmd({4{32'h3F800000}}, {4{32'h3F800000}}, 1'b0, 1'b0, "add_1p1");
    check("add_1p1 value", result, {4{32'h40000000}});
    run_cmd({4{32'h40400000}}, {4{32'h3F800000}}, 1'b1, 1'b0, "sub_3m1");
    check("sub_3m1 value", result, {4{32'h40000000}});
    run_cmd({4{32'h3FC00000}}, {4{32'h3F000000}}, 1'b0, 1'b0, "add_1p5");
    check("add_1p5 value", result, {4{32'h40000000}});

    // Element ordering through a pass-through adder.
    mode = 2;
    for (int i = 0; i < LANES; i++) a[i*W +: W] = 32'hA5A50000 | 32'(i);
    run_cmd(a, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, "order");
    check("order value", result, a);

    // start held through DONE, then a new start right after done.
    mode = 1;
    run_cmd({$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, "hold");
    run_cmd({$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, "back2back");

    // Randomized commands against the integer adder model.
    for (int n = 0; n < 4; n++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      run_cmd(a, b, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", n));
    end

    // Reset in the third cycle of ISSUE aborts the command.
    op_a = {$urandom, $urandom, $urandom, $urandom};
    op_b = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort busy", {127'd0, busy}, 128'd0);
    check("abort fa_en", {127'd0, fa_en}, 128'd0);
    check("abort done", {127'd0, done}, 128'd0);
    check("abort result", result, 128'd0);
    check("abort fa_a", {96'd0, fa_a}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    run_cmd({$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, "after_abort");

`ifdef FPADD_SEQ_PERF_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("perf reset cmds", {112'd0, perf_cmds}, 128'd0);
    check("perf reset busy", {96'd0, perf_busy}, 128'd0);
    for (int n = 0; n < 3; n++)
      run_cmd({$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, "perf");
    check("perf cmds", {112'd0, perf_cmds}, 128'd3);
    check("perf busy", {96'd0, perf_busy}, 128'(3 * CMD_CYCLES));
    @(negedge clk);
    force dut.perf_cmds_q = 16'hFFFF;
    @(negedge clk);
    release dut.perf_cmds_q;
    run_cmd({$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, "perf_sat");
    check("perf cmds saturated", {112'd0, perf_cmds}, 128'h0FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
